// File: rtl/sc_demux110_regbank.sv
// sc_demux110_regbank: ten-register write demultiplexer with single writes and
// pointer-driven bursts (IDLE -> BURST -> DONE), a sticky alias flag and a
// synchronous clear.
module sc_demux110_regbank #(
    parameter int NUMBER_DATAWIDTH = 8
) (
    input  logic                        SC_DEMUX110_CLOCK_50,
    input  logic                        SC_DEMUX110_RESET_InHigh,
    input  logic [NUMBER_DATAWIDTH-1:0] SC_DEMUX110_data_InBUS,
    input  logic [3:0]                  SC_DEMUX110_select_InBUS,
    input  logic                        SC_DEMUX110_write_In,
    input  logic                        SC_DEMUX110_burst_In,
    input  logic                        SC_DEMUX110_clear_In,
    output logic [NUMBER_DATAWIDTH-1:0] SC_DEMUX110_data1_OutBUS,
    output logic [NUMBER_DATAWIDTH-1:0] SC_DEMUX110_data2_OutBUS,
    output logic [NUMBER_DATAWIDTH-1:0] SC_DEMUX110_data3_OutBUS,
    output logic [NUMBER_DATAWIDTH-1:0] SC_DEMUX110_data4_OutBUS,
    output logic [NUMBER_DATAWIDTH-1:0] SC_DEMUX110_data5_OutBUS,
    output logic [NUMBER_DATAWIDTH-1:0] SC_DEMUX110_data6_OutBUS,
    output logic [NUMBER_DATAWIDTH-1:0] SC_DEMUX110_data7_OutBUS,
    output logic [NUMBER_DATAWIDTH-1:0] SC_DEMUX110_data8_OutBUS,
    output logic [NUMBER_DATAWIDTH-1:0] SC_DEMUX110_data9_OutBUS,
    output logic [NUMBER_DATAWIDTH-1:0] SC_DEMUX110_data10_OutBUS,
    output logic                        SC_DEMUX110_busy_Out,
    output logic                        SC_DEMUX110_done_Out,
    output logic                        SC_DEMUX110_alias_Out
);

    localparam int          NUM_REGS = 10;
    localparam logic [3:0]  LAST_IDX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [3:0]                  ptr_q, ptr_d;
    logic                        alias_q, alias_d;
    logic [NUMBER_DATAWIDTH-1:0] data_q [NUM_REGS];
    logic [NUMBER_DATAWIDTH-1:0] data_d [NUM_REGS];

    // Write request produced by the FSM, consumed by the register bank.
    logic                        wr_en;
    logic [3:0]                  wr_idx;
    logic                        clr;

    // Out-of-range selects alias onto the last register, like the 10:1 read mux.
    logic [3:0]                  sel_clamped;
    assign sel_clamped = (SC_DEMUX110_select_InBUS > LAST_IDX) ? LAST_IDX
                                                               : SC_DEMUX110_select_InBUS;

    // Next-state, pointer, flag and write-request decode.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves
        // a variable unassigned, which would otherwise infer a latch.
        state_d = state_q;
        ptr_d   = ptr_q;
        alias_d = alias_q;
        wr_en   = 1'b0;
        wr_idx  = 4'd0;
        clr     = 1'b0;

        if (SC_DEMUX110_clear_In) begin
            // Clear wins over any write or burst request in the same cycle.
            clr     = 1'b1;
            state_d = ST_IDLE;
            ptr_d   = 4'd0;
            alias_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (SC_DEMUX110_burst_In) begin
                        // Burst start swallows a coincident write strobe.
                        ptr_d   = sel_clamped;
                        state_d = ST_BURST;
                    end else if (SC_DEMUX110_write_In) begin
                        wr_en  = 1'b1;
                        wr_idx = sel_clamped;
                        if (SC_DEMUX110_select_InBUS > LAST_IDX) begin
                            alias_d = 1'b1;
                        end
                    end
                end
                ST_BURST: begin
                    // write_In low is a stall: nothing moves.
                    if (SC_DEMUX110_write_In) begin
                        wr_en  = 1'b1;
                        wr_idx = ptr_q;
                        if (ptr_q == LAST_IDX) begin
                            state_d = ST_DONE;
                        end else begin
                            ptr_d = ptr_q + 4'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Register bank next values: clear all, or update exactly the addressed entry.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            data_d[i] = data_q[i];
            if (clr) begin
                data_d[i] = '0;
            end else if (wr_en && (wr_idx == 4'(i))) begin
                data_d[i] = SC_DEMUX110_data_InBUS;
            end
        end
    end

    // State, pointer and alias flag registers.
    always_ff @(posedge SC_DEMUX110_CLOCK_50 or posedge SC_DEMUX110_RESET_InHigh) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples its inputs from before the edge, independent of statement order.
        if (SC_DEMUX110_RESET_InHigh) begin
            state_q <= ST_IDLE;
            ptr_q   <= 4'd0;
            alias_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            alias_q <= alias_d;
        end
    end

    // Data register bank.
    always_ff @(posedge SC_DEMUX110_CLOCK_50 or posedge SC_DEMUX110_RESET_InHigh) begin
        // NOTE: the bank is ten flop-based registers that must read 0 straight out
        // of reset, so it is reset like any other state; a RAM could not be.
        if (SC_DEMUX110_RESET_InHigh) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign SC_DEMUX110_data1_OutBUS  = data_q[0];
    assign SC_DEMUX110_data2_OutBUS  = data_q[1];
    assign SC_DEMUX110_data3_OutBUS  = data_q[2];
    assign SC_DEMUX110_data4_OutBUS  = data_q[3];
    assign SC_DEMUX110_data5_OutBUS  = data_q[4];
    assign SC_DEMUX110_data6_OutBUS  = data_q[5];
    assign SC_DEMUX110_data7_OutBUS  = data_q[6];
    assign SC_DEMUX110_data8_OutBUS  = data_q[7];
    assign SC_DEMUX110_data9_OutBUS  = data_q[8];
    assign SC_DEMUX110_data10_OutBUS = data_q[9];

    assign SC_DEMUX110_busy_Out  = (state_q == ST_BURST);
    assign SC_DEMUX110_done_Out  = (state_q == ST_DONE);
    assign SC_DEMUX110_alias_Out = alias_q;

endmodule

// File: tb/tb_sc_demux110_regbank.sv
// Directed testbench for sc_demux110_regbank: single writes, aliasing, bursts,
// clamping, clear and asynchronous reset, with hand-computed expectations.
module tb_sc_demux110_regbank;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] data_in;
    logic [3:0]   sel;
    logic         wr;
    logic         burst;
    logic         clear;
    logic [W-1:0] dout [10];
    logic         busy;
    logic         done;
    logic         alias_f;

    logic [W-1:0] exp_bank [10];
    int           n_checks;
    int           n_fail;

    sc_demux110_regbank #(.NUMBER_DATAWIDTH(W)) dut (
        .SC_DEMUX110_CLOCK_50      (clk),
        .SC_DEMUX110_RESET_InHigh  (rst),
        .SC_DEMUX110_data_InBUS    (data_in),
        .SC_DEMUX110_select_InBUS  (sel),
        .SC_DEMUX110_write_In      (wr),
        .SC_DEMUX110_burst_In      (burst),
        .SC_DEMUX110_clear_In      (clear),
        .SC_DEMUX110_data1_OutBUS  (dout[0]),
        .SC_DEMUX110_data2_OutBUS  (dout[1]),
        .SC_DEMUX110_data3_OutBUS  (dout[2]),
        .SC_DEMUX110_data4_OutBUS  (dout[3]),
        .SC_DEMUX110_data5_OutBUS  (dout[4]),
        .SC_DEMUX110_data6_OutBUS  (dout[5]),
        .SC_DEMUX110_data7_OutBUS  (dout[6]),
        .SC_DEMUX110_data8_OutBUS  (dout[7]),
        .SC_DEMUX110_data9_OutBUS  (dout[8]),
        .SC_DEMUX110_data10_OutBUS (dout[9]),
        .SC_DEMUX110_busy_Out      (busy),
        .SC_DEMUX110_done_Out      (done),
        .SC_DEMUX110_alias_Out     (alias_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        data_in = '0;
        sel     = 4'd0;
        wr      = 1'b0;
        burst   = 1'b0;
        clear   = 1'b0;
    endtask

    task automatic zero_exp();
        for (int i = 0; i < 10; i++) exp_bank[i] = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        zero_exp();
        repeat (2) tick();
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (dout[i] !== exp_bank[i]) begin
                n_fail++;
                $display("FAIL reset data%0d: got %h expected %h", i + 1, dout[i], exp_bank[i]);
            end
        end
        n_checks++;
        if ({busy, done, alias_f} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset flags busy/done/alias: got %b expected 000", {busy, done, alias_f});
        end
        #3 rst = 1'b0;
    endtask

    task automatic test_single_write();
        sel = 4'd3; data_in = 8'hA5; wr = 1'b1;
        tick();
        wr = 1'b0;
        exp_bank[3] = 8'hA5;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (dout[i] !== exp_bank[i]) begin
                n_fail++;
                $display("FAIL single_write data%0d: got %h expected %h", i + 1, dout[i], exp_bank[i]);
            end
        end
        n_checks++;
        if ({busy, done, alias_f} !== 3'b000) begin
            n_fail++;
            $display("FAIL single_write flags: got %b expected 000", {busy, done, alias_f});
        end
    endtask

    task automatic test_alias();
        sel = 4'd12; data_in = 8'h3C; wr = 1'b1;
        tick();
        wr = 1'b0;
        exp_bank[9] = 8'h3C;
        n_checks++;
        if (dout[9] !== 8'h3C || alias_f !== 1'b1) begin
            n_fail++;
            $display("FAIL alias_write data10/alias: got %h/%b expected 3c/1", dout[9], alias_f);
        end
        n_checks++;
        if (dout[3] !== 8'hA5) begin
            n_fail++;
            $display("FAIL alias_write data4 held: got %h expected a5", dout[3]);
        end
        repeat (3) tick();
        n_checks++;
        if (alias_f !== 1'b1) begin
            n_fail++;
            $display("FAIL alias_sticky: got %b expected 1", alias_f);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        zero_exp();
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (dout[i] !== exp_bank[i]) begin
                n_fail++;
                $display("FAIL clear data%0d: got %h expected %h", i + 1, dout[i], exp_bank[i]);
            end
        end
        n_checks++;
        if (alias_f !== 1'b0) begin
            n_fail++;
            $display("FAIL clear alias: got %b expected 0", alias_f);
        end
    endtask

    task automatic test_burst();
        int busy_cycles;
        int done_cycles;
        busy_cycles = 0;
        done_cycles = 0;
        // Burst start with a coincident write strobe that must be ignored.
        burst = 1'b1; sel = 4'd7; wr = 1'b1; data_in = 8'hFF;
        tick();
        if (busy) busy_cycles++;
        n_checks++;
        if (dout[7] !== 8'h00 || dout[9] !== 8'h00 || alias_f !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_start no write: got data8=%h data10=%h alias=%b expected 00/00/0",
                     dout[7], dout[9], alias_f);
        end
        // burst_In and select are ignored inside BURST.
        burst = 1'b1; sel = 4'd0; wr = 1'b1; data_in = 8'h11;
        tick();
        if (busy) busy_cycles++;
        burst = 1'b0; wr = 1'b0; data_in = 8'hEE;
        tick();
        if (busy) busy_cycles++;
        n_checks++;
        if (dout[7] !== 8'h11 || dout[8] !== 8'h00) begin
            n_fail++;
            $display("FAIL burst_stall: got data8=%h data9=%h expected 11/00", dout[7], dout[8]);
        end
        wr = 1'b1; data_in = 8'h22;
        tick();
        if (busy) busy_cycles++;
        data_in = 8'h33;
        tick();
        if (busy) busy_cycles++;
        if (done) done_cycles++;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_done_pulse: got done=%b busy=%b expected 1/0", done, busy);
        end
        // Write offered during DONE must not land anywhere.
        wr = 1'b1; sel = 4'd0; data_in = 8'h99;
        tick();
        wr = 1'b0;
        if (done) done_cycles++;
        repeat (2) begin
            tick();
            if (done) done_cycles++;
            if (busy) busy_cycles++;
        end
        exp_bank[7] = 8'h11; exp_bank[8] = 8'h22; exp_bank[9] = 8'h33;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (dout[i] !== exp_bank[i]) begin
                n_fail++;
                $display("FAIL burst data%0d: got %h expected %h", i + 1, dout[i], exp_bank[i]);
            end
        end
        n_checks++;
        if (busy_cycles != 4) begin
            n_fail++;
            $display("FAIL burst busy_cycles: got %0d expected 4", busy_cycles);
        end
        n_checks++;
        if (done_cycles != 1) begin
            n_fail++;
            $display("FAIL burst done_cycles: got %0d expected 1", done_cycles);
        end
    endtask

    task automatic test_burst_clamp();
        burst = 1'b1; sel = 4'd14;
        tick();
        burst = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL clamp_start busy: got %b expected 1", busy);
        end
        wr = 1'b1; data_in = 8'h77;
        tick();
        wr = 1'b0;
        exp_bank[9] = 8'h77;
        n_checks++;
        if (dout[9] !== 8'h77 || done !== 1'b1 || alias_f !== 1'b0) begin
            n_fail++;
            $display("FAIL clamp data10/done/alias: got %h/%b/%b expected 77/1/0", dout[9], done, alias_f);
        end
        n_checks++;
        if (dout[8] !== 8'h22) begin
            n_fail++;
            $display("FAIL clamp data9 held: got %h expected 22", dout[8]);
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clamp return idle: got done=%b busy=%b expected 0/0", done, busy);
        end
    endtask

    task automatic test_clear_mid_burst();
        burst = 1'b1; sel = 4'd0;
        tick();
        burst = 1'b0;
        wr = 1'b1; data_in = 8'hAA;
        tick();
        n_checks++;
        if (dout[0] !== 8'hAA) begin
            n_fail++;
            $display("FAIL clear_mid_burst pre data1: got %h expected aa", dout[0]);
        end
        clear = 1'b1; wr = 1'b1; burst = 1'b1; data_in = 8'hBB;
        tick();
        clear = 1'b0; wr = 1'b0; burst = 1'b0;
        zero_exp();
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (dout[i] !== exp_bank[i]) begin
                n_fail++;
                $display("FAIL clear_mid_burst data%0d: got %h expected %h", i + 1, dout[i], exp_bank[i]);
            end
        end
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_mid_burst busy/done: got %b/%b expected 0/0", busy, done);
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_mid_burst later busy/done: got %b/%b expected 0/0", busy, done);
        end
    endtask

    task automatic test_async_reset();
        sel = 4'd5; data_in = 8'h5A; wr = 1'b1;
        tick();
        wr = 1'b0;
        burst = 1'b1; sel = 4'd2;
        tick();
        burst = 1'b0;
        wr = 1'b1; data_in = 8'h66;
        tick();
        wr = 1'b0;
        n_checks++;
        if (dout[5] !== 8'h5A || dout[2] !== 8'h66 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset pre: got data6=%h data3=%h busy=%b expected 5a/66/1",
                     dout[5], dout[2], busy);
        end
        // Assert reset mid-cycle, well away from any clock edge.
        #2 rst = 1'b1;
        #1;
        zero_exp();
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (dout[i] !== exp_bank[i]) begin
                n_fail++;
                $display("FAIL async_reset data%0d: got %h expected %h", i + 1, dout[i], exp_bank[i]);
            end
        end
        n_checks++;
        if ({busy, done, alias_f} !== 3'b000) begin
            n_fail++;
            $display("FAIL async_reset flags: got %b expected 000", {busy, done, alias_f});
        end
        #1 rst = 1'b0;
    endtask

    task automatic test_first_edge_after_reset();
        sel = 4'd1; data_in = 8'h42; wr = 1'b1;
        tick();
        wr = 1'b0;
        exp_bank[1] = 8'h42;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (dout[i] !== exp_bank[i]) begin
                n_fail++;
                $display("FAIL first_edge data%0d: got %h expected %h", i + 1, dout[i], exp_bank[i]);
            end
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL first_edge busy: got %b expected 0", busy);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        idle_inputs();
        zero_exp();
        test_reset();
        test_single_write();
        test_alias();
        test_burst();
        test_burst_clamp();
        test_clear_mid_burst();
        test_async_reset();
        test_first_edge_after_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
